// File: rtl/brightness_pkg.sv
// brightness_pkg: shared widths and writer FSM states for the brightness-filter datapath.
package brightness_pkg;
    localparam int RAM_ADDR_WIDTH = 6;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int PE_DATA_WIDTH  = 16;
    localparam int DEPTH          = 4;
    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} writer_state_t;
endpackage

// File: rtl/lane_saturator.sv
// lane_saturator: clamps a signed array lane into the unsigned pixel range.
module lane_saturator #(
    parameter int PE_DATA_WIDTH  = brightness_pkg::PE_DATA_WIDTH,
    parameter int RAM_DATA_WIDTH = brightness_pkg::RAM_DATA_WIDTH
) (
    input  logic [PE_DATA_WIDTH-1:0]  value,
    output logic [RAM_DATA_WIDTH-1:0] pixel
);
    logic neg, over;
    always_comb begin
        neg   = value[PE_DATA_WIDTH-1];
        over  = |value[PE_DATA_WIDTH-2:RAM_DATA_WIDTH];
        pixel = neg ? '0 : over ? '1 : value[RAM_DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/ram_result_writer.sv
// ram_result_writer: unpacks array result vectors, clamps each lane and writes them to the output RAM.
module ram_result_writer #(
    parameter int RAM_ADDR_WIDTH = brightness_pkg::RAM_ADDR_WIDTH,
    parameter int RAM_DATA_WIDTH = brightness_pkg::RAM_DATA_WIDTH,
    parameter int PE_DATA_WIDTH  = brightness_pkg::PE_DATA_WIDTH,
    parameter int DEPTH          = brightness_pkg::DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [PE_DATA_WIDTH*DEPTH-1:0] data_in,
    input  logic                           data_valid,
    output logic                           ready,
    output logic [RAM_ADDR_WIDTH-1:0]      ram_address,
    output logic [RAM_DATA_WIDTH-1:0]      ram_wdata,
    output logic                           ram_we,
    output logic                           done
);
    import brightness_pkg::*;
    localparam int LW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    writer_state_t state;
    logic [PE_DATA_WIDTH-1:0]  lanes [DEPTH];
    logic [LW-1:0]             lane;
    logic [RAM_ADDR_WIDTH-1:0] ptr;
    logic [RAM_DATA_WIDTH-1:0] sat;
    lane_saturator #(.PE_DATA_WIDTH(PE_DATA_WIDTH), .RAM_DATA_WIDTH(RAM_DATA_WIDTH)) u_sat (
        .value(lanes[lane]),
        .pixel(sat)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            lane  <= '0;
            ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) lanes[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= WAIT;
                    ptr   <= '0;
                end
                WAIT: if (data_valid) begin
                    for (int i = 0; i < DEPTH; i++) lanes[i] <= data_in[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
                    lane  <= '0;
                    state <= WRITE;
                end
                WRITE: begin
                    ptr  <= ptr + 1'b1;
                    lane <= lane + 1'b1;
                    // pointer wraps naturally, so IDLE shows address 0 after a full frame
                    if (lane == LW'(DEPTH-1)) state <= &ptr ? DONE : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        ready       = state == WAIT;
        ram_we      = state == WRITE;
        done        = state == DONE;
        ram_address = ptr;
        ram_wdata   = ram_we ? sat : '0;
    end
endmodule

// File: tb/tb_ram_result_writer.sv
// tb_ram_result_writer: directed scenario checks for ram_result_writer at default parameters.
module tb_ram_result_writer;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, data_valid = 1'b0;
    logic [63:0] data_in = '0;
    logic        ready, ram_we, done;
    logic [5:0]  ram_address;
    logic [7:0]  ram_wdata;
    logic [7:0]  mem [64];
    int total = 0, bad = 0, wr_count = 0;

    ram_result_writer dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .data_valid(data_valid),
        .ready(ready), .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_we(ram_we), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (ram_we) begin
        mem[ram_address] <= ram_wdata;
        wr_count <= wr_count + 1;
    end

    function automatic logic [63:0] pack4(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start = 1'b0;
        data_valid = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic go;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] v);
        data_in = v;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({ready, ram_we, done, ram_address, ram_wdata} !== 17'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b we=%b done=%b addr=%0d wd=%h want all 0", ready, ram_we, done, ram_address, ram_wdata);
        end
        #1 reset = 1'b1;
        step();
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %b want 0", ready); end
    endtask

    task automatic test_single;
        go();
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL single_ready_after_start: got %b want 1", ready); end
        data_in = pack4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({ram_we, ready, ram_address, ram_wdata} !== {1'b1, 1'b0, 6'(i), 8'((i + 1) * 16)}) begin
                bad++;
                $display("FAIL single_write%0d: got we=%b rdy=%b addr=%0d wd=%h want we=1 rdy=0 addr=%0d wd=%h", i, ram_we, ready, ram_address, ram_wdata, i, (i + 1) * 16);
            end
            step();
        end
        total++;
        if ({ready, ram_we} !== 2'b10) begin bad++; $display("FAIL single_ready_again: got rdy=%b we=%b want rdy=1 we=0", ready, ram_we); end
    endtask

    task automatic test_saturation;
        logic [7:0] exp [4];
        exp = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
        data_in = pack4(16'h0100, 16'hFFFF, 16'h00FF, 16'h7FFF);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({ram_we, ram_address, ram_wdata} !== {1'b1, 6'(4 + i), exp[i]}) begin
                bad++;
                $display("FAIL sat_lane%0d: got we=%b addr=%0d wd=%h want we=1 addr=%0d wd=%h", i, ram_we, ram_address, ram_wdata, 4 + i, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_full_frame;
        do_reset();
        step();
        go();
        for (int v = 0; v < 16; v++) begin
            data_in = pack4(16'(4 * v + 1), 16'(4 * v + 2), 16'(4 * v + 3), 16'(4 * v + 4));
            data_valid = 1'b1;
            step();
            data_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
                total++;
                if ({ram_we, done, ram_address} !== {1'b1, 1'b0, 6'(4 * v + j)}) begin
                    bad++;
                    $display("FAIL frame_write%0d: got we=%b done=%b addr=%0d want we=1 done=0 addr=%0d", 4 * v + j, ram_we, done, ram_address, 4 * v + j);
                end
                step();
            end
        end
        total++;
        if ({done, ready, ram_we} !== 3'b100) begin bad++; $display("FAIL frame_done: got done=%b rdy=%b we=%b want done=1 rdy=0 we=0", done, ready, ram_we); end
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if ({done, ready, ram_we, ram_address} !== 9'h0) begin
            bad++;
            $display("FAIL frame_idle: got done=%b rdy=%b we=%b addr=%0d want all 0", done, ready, ram_we, ram_address);
        end
        step();
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL start_in_done_ignored: got rdy=%b want 0", ready); end
        for (int i = 0; i < 64; i++) begin
            total++;
            if (mem[i] !== 8'(i + 1)) begin bad++; $display("FAIL frame_ram[%0d]: got %h want %h", i, mem[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] a, c;
        do_reset();
        step();
        go();
        a = pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        c = pack4(16'h000A, 16'h000B, 16'h000C, 16'h000D);
        data_in = a;
        data_valid = 1'b1;
        step();
        for (int j = 0; j < 4; j++) begin
            data_in = (j == 3) ? c : pack4(16'(8'h50 + j), 16'h0066, 16'h0077, 16'h0088);
            total++;
            if ({ram_we, ready, ram_address, ram_wdata} !== {1'b1, 1'b0, 6'(j), 8'(j + 1)}) begin
                bad++;
                $display("FAIL bp_a%0d: got we=%b rdy=%b addr=%0d wd=%h want we=1 rdy=0 addr=%0d wd=%h", j, ram_we, ready, ram_address, ram_wdata, j, j + 1);
            end
            step();
        end
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL bp_ready: got %b want 1", ready); end
        step();
        data_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            total++;
            if ({ram_we, ram_address, ram_wdata} !== {1'b1, 6'(4 + j), 8'(8'h0A + j)}) begin
                bad++;
                $display("FAIL bp_c%0d: got we=%b addr=%0d wd=%h want we=1 addr=%0d wd=%h", j, ram_we, ram_address, ram_wdata, 4 + j, 8'h0A + j);
            end
            step();
        end
        total++;
        if ({ready, ram_we, ram_address, wr_count} !== {1'b1, 1'b0, 6'd8, 32'(wr_count)} || mem[7] !== 8'h0D) begin
            bad++;
            $display("FAIL bp_end: got rdy=%b we=%b addr=%0d mem7=%h want rdy=1 we=0 addr=8 mem7=0d", ready, ram_we, ram_address, mem[7]);
        end
    endtask

    task automatic test_reset_mid_write;
        int c;
        do_reset();
        step();
        go();
        for (int v = 0; v < 5; v++) send(pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044));
        data_in = pack4(16'h0055, 16'h0066, 16'h0077, 16'h0088);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        repeat (2) step();
        total++;
        if ({ram_we, ram_address} !== {1'b1, 6'd22}) begin bad++; $display("FAIL rst_pre: got we=%b addr=%0d want we=1 addr=22", ram_we, ram_address); end
        c = wr_count;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({ready, ram_we, done, ram_address, ram_wdata} !== 17'h0) begin
            bad++;
            $display("FAIL rst_async: got rdy=%b we=%b done=%b addr=%0d wd=%h want all 0", ready, ram_we, done, ram_address, ram_wdata);
        end
        repeat (3) step();
        total++;
        if (wr_count !== c) begin bad++; $display("FAIL rst_no_writes: got %0d writes want %0d", wr_count, c); end
        reset = 1'b1;
        step();
        go();
        data_in = pack4(16'h0021, 16'h0000, 16'h0000, 16'h0000);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        total++;
        if ({ram_we, ram_address, ram_wdata} !== {1'b1, 6'd0, 8'h21}) begin
            bad++;
            $display("FAIL rst_restart: got we=%b addr=%0d wd=%h want we=1 addr=0 wd=21", ram_we, ram_address, ram_wdata);
        end
    endtask

    task automatic test_start_collision;
        do_reset();
        step();
        data_in = pack4(16'h0031, 16'h0032, 16'h0033, 16'h0034);
        data_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if ({ready, ram_we} !== 2'b10) begin bad++; $display("FAIL coll_no_capture: got rdy=%b we=%b want rdy=1 we=0", ready, ram_we); end
        step();
        data_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if ({ram_we, ram_address, ram_wdata} !== {1'b1, 6'd1, 8'h32}) begin
            bad++;
            $display("FAIL coll_start_in_write: got we=%b addr=%0d wd=%h want we=1 addr=1 wd=32", ram_we, ram_address, ram_wdata);
        end
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if ({ready, ram_we, ram_address} !== {1'b1, 1'b0, 6'd4}) begin
            bad++;
            $display("FAIL coll_start_in_wait: got rdy=%b we=%b addr=%0d want rdy=1 we=0 addr=4", ready, ram_we, ram_address);
        end
        data_in = pack4(16'h0041, 16'h0042, 16'h0043, 16'h0044);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        total++;
        if ({ram_we, ram_address, ram_wdata} !== {1'b1, 6'd4, 8'h41}) begin
            bad++;
            $display("FAIL coll_next_vector: got we=%b addr=%0d wd=%h want we=1 addr=4 wd=41", ram_we, ram_address, ram_wdata);
        end
        total++;
        if (mem[0] !== 8'h31) begin bad++; $display("FAIL coll_first_write: got %h want 31", mem[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_full_frame();
        test_back_to_back();
        test_reset_mid_write();
        test_start_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
